// File: rtl/ascon_perm_seq_pkg.sv
// rtl/ascon_perm_seq_pkg.sv - shared types, round counts and round-constant helper
package ascon_pkg;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 8;

  typedef logic [63:0] word_t;

  // Index 4 is x0 so the packed vector matches {x0,x1,x2,x3,x4}
  typedef logic [4:0][63:0] ascon_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {~r, r};
  endfunction

endpackage

// File: rtl/ascon_perm_seq_if.sv
// rtl/ascon_perm_seq_if.sv - start/done handshake and state buses of the permutation sequencer
interface ascon_perm_seq_if;

  logic                    start_i;
  logic [3:0]              rounds_i;
  ascon_pkg::ascon_state_t state_i;
  logic                    ready_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    ack_i;
  ascon_pkg::ascon_state_t state_o;

  modport slave (
    input  start_i, rounds_i, state_i, ack_i,
    output ready_o, busy_o, done_o, state_o
  );

  modport master (
    output start_i, rounds_i, state_i, ack_i,
    input  ready_o, busy_o, done_o, state_o
  );

endinterface

// File: rtl/ascon_perm_seq_round.sv
// rtl/ascon_perm_seq_round.sv - one combinational ASCON round: constant add, S-box, linear layer
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   round_i,
  output ascon_state_t state_o
);

  function automatic word_t ror(input word_t x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  word_t x0, x1, x2, x3, x4;
  word_t t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i[4];
    x1 = state_i[3];
    x2 = state_i[2] ^ {56'd0, rc(round_i)};
    x3 = state_i[1];
    x4 = state_i[0];

    // Bitsliced S-box: every bit position is one 5-bit column
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o[4] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    state_o[3] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    state_o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    state_o[1] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    state_o[0] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
  end

endmodule

// File: rtl/ascon_perm_seq.sv
// rtl/ascon_perm_seq.sv - iterative p^12 / p^8 sequencer applying UNROLL rounds per clock
module ascon_perm_seq
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ascon_perm_seq_if.slave   bus
);

  fsm_e         state_q, state_d;
  logic [3:0]   r_q, r_d;
  ascon_state_t st_q, st_d;

  ascon_state_t chain [UNROLL+1];

  assign chain[0] = st_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_round u_round (
      .state_i (chain[k]),
      .round_i (r_q + 4'(k)),
      .state_o (chain[k+1])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      r_q     <= 4'd0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    st_d    = st_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          st_d    = bus.state_i;
          // Anything other than 8 runs the full 12 rounds
          r_d     = (bus.rounds_i == 4'(ROUNDS_B)) ? 4'(ROUNDS_A - ROUNDS_B) : 4'd0;
        end
      end
      RUN: begin
        st_d = chain[UNROLL];
        r_d  = r_q + 4'(UNROLL);
        if (r_q + 4'(UNROLL) == 4'(ROUNDS_A)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ack_i) begin
          state_d = IDLE;
          r_d     = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o = (state_q == IDLE);
    bus.busy_o  = (state_q == RUN);
    bus.done_o  = (state_q == DONE);
    bus.state_o = st_q;
  end

endmodule

// File: tb/tb_ascon_perm_seq.sv
// tb/tb_ascon_perm_seq.sv - scoreboard bench driving UNROLL=1/2/4 sequencers with one stimulus stream
module tb_ascon_perm_seq;

  localparam int UN [3] = '{1, 2, 4};
  localparam int SBOX [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                               30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  typedef struct {
    logic [319:0] st;
    int           acc;
    int           nr;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   rounds;
  logic [319:0] st_in;
  logic         auto_ack;
  logic         man_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t         q [3][$];
  exp_t         mon_e;
  logic         dprev [3];
  logic         aprev [3];
  logic [319:0] held [3];

  logic         rdy_w [3];
  logic         bsy_w [3];
  logic         dn_w  [3];
  logic         ack_w [3];
  logic [319:0] so_w  [3];

  ascon_perm_seq_if i1 ();
  ascon_perm_seq_if i2 ();
  ascon_perm_seq_if i4 ();

  ascon_perm_seq #(.UNROLL(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(i1));
  ascon_perm_seq #(.UNROLL(2)) u2 (.clk_i(clk), .rst_i(rst), .bus(i2));
  ascon_perm_seq #(.UNROLL(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(i4));

  assign i1.start_i = start;  assign i1.rounds_i = rounds;  assign i1.state_i = st_in;
  assign i2.start_i = start;  assign i2.rounds_i = rounds;  assign i2.state_i = st_in;
  assign i4.start_i = start;  assign i4.rounds_i = rounds;  assign i4.state_i = st_in;
  assign i1.ack_i = auto_ack ? i1.done_o : man_ack;
  assign i2.ack_i = auto_ack ? i2.done_o : man_ack;
  assign i4.ack_i = auto_ack ? i4.done_o : man_ack;

  assign rdy_w[0] = i1.ready_o;  assign bsy_w[0] = i1.busy_o;  assign dn_w[0] = i1.done_o;
  assign rdy_w[1] = i2.ready_o;  assign bsy_w[1] = i2.busy_o;  assign dn_w[1] = i2.done_o;
  assign rdy_w[2] = i4.ready_o;  assign bsy_w[2] = i4.busy_o;  assign dn_w[2] = i4.done_o;
  assign ack_w[0] = i1.ack_i;    assign ack_w[1] = i2.ack_i;   assign ack_w[2] = i4.ack_i;
  assign so_w[0]  = i1.state_o;  assign so_w[1]  = i2.state_o; assign so_w[2]  = i4.state_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference permutation: S-box by table lookup per column, rounds numbered from 12-nr
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
    logic [63:0] x [5];
    logic [4:0]  v, o;
    logic [319:0] res;
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    for (int rd = 12 - nr; rd < 12; rd++) begin
      x[2] = x[2] ^ 64'((15 - rd) * 16 + rd);
      for (int j = 0; j < 64; j++) begin
        v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o = 5'(SBOX[v]);
        x[0][j] = o[4]; x[1][j] = o[3]; x[2][j] = o[2]; x[3][j] = o[1]; x[4][j] = o[0];
      end
      for (int w = 0; w < 5; w++) x[w] = x[w] ^ rotr(x[w], ROT_A[w]) ^ rotr(x[w], ROT_B[w]);
    end
    for (int w = 0; w < 5; w++) res[319 - 64*w -: 64] = x[w];
    return res;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        if (dprev[i] && aprev[i]) begin
          checks++;
          if (!rdy_w[i] || dn_w[i]) begin
            errors++;
            $display("FAIL ack_to_idle u=%0d ready=%b done=%b required ready=1 done=0",
                     UN[i], rdy_w[i], dn_w[i]);
          end
        end
        if (dn_w[i] && !dprev[i]) begin
          if (q[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done u=%0d cyc=%0d required no done", UN[i], cyc);
          end else begin
            mon_e = q[i].pop_front();
            checks++;
            if (so_w[i] !== mon_e.st) begin
              errors++;
              $display("FAIL result u=%0d got=%h required=%h", UN[i], so_w[i], mon_e.st);
            end
            checks++;
            if (cyc - mon_e.acc != mon_e.nr / UN[i]) begin
              errors++;
              $display("FAIL latency u=%0d got=%0d required=%0d", UN[i], cyc - mon_e.acc,
                       mon_e.nr / UN[i]);
            end
          end
          held[i] = so_w[i];
        end else if (dn_w[i] && dprev[i]) begin
          checks++;
          if (so_w[i] !== held[i] || rdy_w[i] || bsy_w[i]) begin
            errors++;
            $display("FAIL done_hold u=%0d got=%h ready=%b busy=%b required=%h ready=0 busy=0",
                     UN[i], so_w[i], rdy_w[i], bsy_w[i], held[i]);
          end
        end
        dprev[i] = dn_w[i];
        aprev[i] = ack_w[i];
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy_w[i] !== 1'b1 || bsy_w[i] !== 1'b0 || dn_w[i] !== 1'b0 || so_w[i] !== '0) begin
        errors++;
        $display("FAIL %s u=%0d ready=%b busy=%b done=%b state_nonzero=%b required 1/0/0/0",
                 tag, UN[i], rdy_w[i], bsy_w[i], dn_w[i], |so_w[i]);
      end
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      dprev[i] = 1'b0;
      aprev[i] = 1'b0;
    end
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals(tag);
    flush();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(rdy_w[0] && rdy_w[1] && rdy_w[2])) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL ready_timeout cyc=%0d required ready within 300 cycles", cyc);
        return;
      end
    end
  endtask

  task automatic issue_start(input logic [319:0] s, input logic [3:0] nr);
    exp_t e;
    int   eff;
    wait_ready();
    eff    = (nr == 4'd8) ? 8 : 12;
    e.st   = ref_perm(s, eff);
    e.acc  = cyc + 1;
    e.nr   = eff;
    start  = 1'b1;
    st_in  = s;
    rounds = nr;
    for (int i = 0; i < 3; i++) q[i].push_back(e);
    @(negedge clk);
    start  = 1'b0;
    st_in  = rand320();
    rounds = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rdy_w[0] && rdy_w[1] && rdy_w[2] &&
             q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0)) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL idle_timeout cyc=%0d pending=%0d required 0", cyc, q[0].size());
        return;
      end
    end
  endtask

  logic [319:0] init_st;
  int           sel, n;

  initial begin
    rst = 1'b1; start = 1'b0; rounds = 4'd0; st_in = '0;
    auto_ack = 1'b1; man_ack = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    check_reset_vals("reset_state");
    rst = 1'b0;
    @(negedge clk);

    issue_start('0, 4'd12);
    wait_idle();

    init_st = {64'h00001000808c0001, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
               64'h0001020304050607, 64'h08090a0b0c0d0e0f};
    issue_start(init_st, 4'd8);
    wait_idle();

    // Manual acknowledge: stray start/ack in RUN, stray start in DONE, hold done 5 cycles
    auto_ack = 1'b0;
    issue_start(rand320(), 4'd12);
    start = 1'b1; st_in = rand320(); rounds = 4'd8; man_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; man_ack = 1'b0;
    n = 0;
    while (!(dn_w[0] && dn_w[1] && dn_w[2]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL done_timeout got=%0d required <40 cycles", n);
    end
    start = 1'b1; st_in = rand320();
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    auto_ack = 1'b1;
    wait_idle();

    issue_start(rand320(), 4'd12);
    repeat (3) @(negedge clk);
    async_reset("abort_reset");
    issue_start(rand320(), 4'd12);
    wait_idle();
    issue_start(rand320(), 4'd8);
    wait_idle();

    for (int t = 0; t < 1000; t++) begin
      sel = $urandom_range(0, 9);
      issue_start(rand320(), (sel < 5) ? 4'd12 : (sel < 9) ? 4'd8 : 4'($urandom_range(0, 15)));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
